key_entry_sequencer: RTL and testbench
======================================

# key_entry_sequencer

Control FSM for the alarm-clock keypad path. Sits between the keypad/button inputs and the key-register, alarm-register and time-counter datapath inside `alarm_clock_top`. Sequences digit entry into the key shift register, commits a 4-digit entry as the new current time or the new alarm time, selects what the display mux shows, and abandons partial entries after an inactivity timeout.

## Interface
- `NOKEY`, 10: key code meaning "no key pressed". Codes 11–15 are also treated as no key.
- `TIMEOUT`, 10: number of `one_second` pulses of inactivity before an entry is abandoned. Range 1–15.
- `clock` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clock` rising edge.
- `one_second` in 1: one-cycle pulse from the timegen block. Already scaled by fastwatch upstream.
- `key` in 4: keypad code. 0–9 are digits; `NOKEY`/11–15 mean idle.
- `time_button` in 1: level; commits the entry as current time.
- `alarm_button` in 1: level; commits the entry as alarm time, or shows the alarm while held when no entry is pending.
- `shift` out 1: one-cycle pulse; key register shifts in `key`.
- `load_new_c` out 1: one-cycle pulse; time counter loads the key register.
- `load_new_a` out 1: one-cycle pulse; alarm register loads the key register.
- `show_new_time` out 1: level; display mux selects the key register.
- `show_a` out 1: level; display mux selects the alarm register.
- `digit_count` out 3: digits entered in the current entry, saturating at 4.

## Operation
- States: SHOW_TIME, SHOW_ALARM, KEY_STORED, KEY_WAITED, KEY_ENTRY, SET_CURRENT_TIME, SET_ALARM_TIME. 3-bit state register.
- Outputs are Moore, decoded from the registered state.
  - `shift` = KEY_STORED.
  - `load_new_c` = SET_CURRENT_TIME.
  - `load_new_a` = SET_ALARM_TIME.
  - `show_new_time` = KEY_STORED, KEY_WAITED or KEY_ENTRY.
  - `show_a` = SHOW_ALARM.
- Digit = `key` ≤ 9.
- SHOW_TIME:
  - digit → KEY_STORED, with `digit_count` cleared to 0 in the same edge;
  - else `alarm_button` → SHOW_ALARM;
  - else stay.
- SHOW_ALARM: stay while `alarm_button`=1; → SHOW_TIME on release. Digits are ignored here.
- KEY_STORED → KEY_WAITED unconditionally. `digit_count` increments, saturating at 4; the timeout counter clears.
- KEY_WAITED:
  - → KEY_ENTRY when `key` is not a digit (released);
  - → SHOW_TIME on timeout.
- KEY_ENTRY: priority is timeout > `time_button` > `alarm_button` > digit.
  - `time_button` with `digit_count`=4 → SET_CURRENT_TIME.
  - `alarm_button` with `digit_count`=4 → SET_ALARM_TIME.
  - A button pressed with `digit_count`<4 is ignored (stay).
  - digit → KEY_STORED. With `digit_count`=4 the shift still occurs; the oldest digit drops out of the key register.
- SET_CURRENT_TIME and SET_ALARM_TIME → SHOW_TIME unconditionally. `digit_count` clears.
- Timeout counter:
  - 4 bits; counts `one_second` pulses only in KEY_WAITED and KEY_ENTRY.
  - Timeout is true in the cycle where `one_second`=1 and the count equals `TIMEOUT`-1.
  - Clears on every entry into KEY_STORED and in all other states.
- `digit_count` holds its value through KEY_WAITED/KEY_ENTRY. It is cleared in SHOW_TIME entry paths and on timeout.

## Timing
- Reset (`reset`=0 at an edge): state=SHOW_TIME, `digit_count`=0, timeout count=0. `shift`, `load_new_c`, `load_new_a`, `show_new_time`, `show_a` are all 0 in the following cycle. Reset mid-entry discards the entry with no load pulse.
- Digit sampled at edge N → `shift`=1 for exactly cycle N..N+1. A key held for many cycles produces exactly one `shift`; a new shift requires release to a non-digit first.
- Button sampled in KEY_ENTRY at edge N → load pulse high for exactly one cycle after edge N. `show_new_time` drops in the same cycle the load pulse rises.
- Simultaneous `time_button` and `alarm_button` in KEY_ENTRY: current time wins; the alarm is not loaded.
- Button held across return to SHOW_TIME: `alarm_button` still high in SHOW_TIME → SHOW_ALARM. `time_button` has no effect in SHOW_TIME.
- Timeout and button in the same cycle: timeout wins; no load.
- `one_second` arriving in the KEY_STORED cycle is not counted.

## Test plan
- Reset: hold `reset`=0 for 3 edges with a digit on `key` → all outputs 0, `digit_count`=0. No `shift` occurs until the first edge with `reset`=1.
- Set time 11:23:
  - per digit, `key`=d for 3 cycles then 10 for 1 cycle; then `time_button` for 1 cycle;
  - expect exactly 4 `shift` pulses and `digit_count`=1,2,3,4;
  - expect 1 `load_new_c` pulse, then `show_new_time`=0 and state SHOW_TIME.
- Set alarm 11:30 the same way using `alarm_button` → one `load_new_a`, no `load_new_c`, no `show_a` after release.
- Partial entry: enter 2 digits, press `time_button` → no load pulse; state stays KEY_ENTRY with `show_new_time`=1. Then 10 `one_second` pulses (`TIMEOUT`=10) → SHOW_TIME, `digit_count`=0, no load.
- Alarm view: in SHOW_TIME hold `alarm_button` 20 cycles → `show_a`=1 from cycle 2 through release+1. `key`=5 pressed meanwhile produces no `shift`.
- Both buttons together after 4 digits → `load_new_c` only. A fifth digit before the button → 5 `shift` pulses, `digit_count` stays 4, and the load still happens.

Source files
------------

// File: rtl/key_entry_sequencer.sv
// key_entry_sequencer: keypad control FSM for the alarm clock.
// Sequences digit entry into the key shift register. Commits a 4-digit
// entry as the current time or as the alarm time. Drives the display-mux
// selects and abandons an idle entry after TIMEOUT one_second pulses.
module key_entry_sequencer #(
  parameter logic [3:0]  NOKEY   = 4'd10,
  parameter int unsigned TIMEOUT = 10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       one_second,
  input  logic [3:0] key,
  input  logic       time_button,
  input  logic       alarm_button,
  output logic       shift,
  output logic       load_new_c,
  output logic       load_new_a,
  output logic       show_new_time,
  output logic       show_a,
  output logic [2:0] digit_count
);

  localparam logic [2:0] S_SHOW_TIME        = 3'd0;
  localparam logic [2:0] S_SHOW_ALARM       = 3'd1;
  localparam logic [2:0] S_KEY_STORED       = 3'd2;
  localparam logic [2:0] S_KEY_WAITED       = 3'd3;
  localparam logic [2:0] S_KEY_ENTRY        = 3'd4;
  localparam logic [2:0] S_SET_CURRENT_TIME = 3'd5;
  localparam logic [2:0] S_SET_ALARM_TIME   = 3'd6;

  localparam logic [2:0] FULL_ENTRY = 3'd4;
  localparam logic [3:0] TO_LAST    = 4'(TIMEOUT - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] digit_cnt_q, digit_cnt_d;
  logic [3:0] to_cnt_q, to_cnt_d;
  logic       is_digit;
  logic       waiting;
  logic       timeout;

  // NOKEY and codes 11-15 all mean "no key"; only 0-9 are digits.
  assign is_digit = (key != NOKEY) && (key <= 4'd9);

  // The inactivity timer only runs while an entry is waiting for input.
  assign waiting = (state_q == S_KEY_WAITED) || (state_q == S_KEY_ENTRY);
  assign timeout = waiting && one_second && (to_cnt_q == TO_LAST);

  // Next-state, digit counter and inactivity timer decode.
  always_comb begin
    // NOTE: every variable gets a default first so no path can leave it
    // unassigned; otherwise a latch would be inferred.
    state_d     = state_q;
    digit_cnt_d = digit_cnt_q;
    to_cnt_d    = 4'd0;

    case (state_q)
      S_SHOW_TIME: begin
        if (is_digit) begin
          state_d     = S_KEY_STORED;
          digit_cnt_d = 3'd0;
        end else if (alarm_button) begin
          state_d = S_SHOW_ALARM;
        end
      end
      S_SHOW_ALARM: begin
        if (!alarm_button) state_d = S_SHOW_TIME;
      end
      S_KEY_STORED: begin
        state_d = S_KEY_WAITED;
        if (digit_cnt_q != FULL_ENTRY) digit_cnt_d = digit_cnt_q + 3'd1;
      end
      S_KEY_WAITED: begin
        if (timeout) begin
          state_d     = S_SHOW_TIME;
          digit_cnt_d = 3'd0;
        end else if (!is_digit) begin
          state_d = S_KEY_ENTRY;
        end
      end
      S_KEY_ENTRY: begin
        // A button with an incomplete entry is swallowed: stay put.
        if (timeout) begin
          state_d     = S_SHOW_TIME;
          digit_cnt_d = 3'd0;
        end else if (time_button) begin
          if (digit_cnt_q == FULL_ENTRY) state_d = S_SET_CURRENT_TIME;
        end else if (alarm_button) begin
          if (digit_cnt_q == FULL_ENTRY) state_d = S_SET_ALARM_TIME;
        end else if (is_digit) begin
          state_d = S_KEY_STORED;
        end
      end
      S_SET_CURRENT_TIME, S_SET_ALARM_TIME: begin
        state_d     = S_SHOW_TIME;
        digit_cnt_d = 3'd0;
      end
      default: begin
        state_d     = S_SHOW_TIME;
        digit_cnt_d = 3'd0;
      end
    endcase

    // Keep counting only while staying in the waiting states. Entering
    // KEY_STORED restarts the count, so a pulse in that cycle is dropped.
    if (waiting && ((state_d == S_KEY_WAITED) || (state_d == S_KEY_ENTRY))) begin
      to_cnt_d = one_second ? (to_cnt_q + 4'd1) : to_cnt_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    if (!reset) begin
      state_q     <= S_SHOW_TIME;
      digit_cnt_q <= 3'd0;
      to_cnt_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      digit_cnt_q <= digit_cnt_d;
      to_cnt_q    <= to_cnt_d;
    end
  end

  // Moore outputs decoded from the registered state.
  assign shift         = (state_q == S_KEY_STORED);
  assign load_new_c    = (state_q == S_SET_CURRENT_TIME);
  assign load_new_a    = (state_q == S_SET_ALARM_TIME);
  assign show_new_time = (state_q == S_KEY_STORED) || (state_q == S_KEY_WAITED)
                      || (state_q == S_KEY_ENTRY);
  assign show_a        = (state_q == S_SHOW_ALARM);
  assign digit_count   = digit_cnt_q;

endmodule

// File: tb/tb_key_entry_sequencer.sv
// tb_key_entry_sequencer: directed and random stimulus for the keypad
// sequencer. Each cycle is compared against a behavioural model built from
// entry-level flags (entry active, waiting for release, pending pulses).
module tb_key_entry_sequencer;

  localparam int TIMEOUT = 10;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       one_second = 1'b0;
  logic [3:0] key = 4'd10;
  logic       time_button = 1'b0;
  logic       alarm_button = 1'b0;
  logic       shift, load_new_c, load_new_a, show_new_time, show_a;
  logic [2:0] digit_count;

  key_entry_sequencer #(.NOKEY(4'd10), .TIMEOUT(TIMEOUT)) dut (
    .clock        (clock),
    .reset        (reset),
    .one_second   (one_second),
    .key          (key),
    .time_button  (time_button),
    .alarm_button (alarm_button),
    .shift        (shift),
    .load_new_c   (load_new_c),
    .load_new_a   (load_new_a),
    .show_new_time(show_new_time),
    .show_a       (show_a),
    .digit_count  (digit_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state.
  bit m_entry, m_shift, m_wait_rel, m_load_c, m_load_a, m_alarm;
  int m_digits, m_secs;

  // Pulse counters observed on the DUT, cleared per directed scenario.
  int shift_cnt, lc_cnt, la_cnt, show_a_cnt;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of the abstract keypad behaviour, using pre-edge inputs.
  task automatic model_step(input logic r, input logic [3:0] k,
                            input logic tb, input logic ab, input logic os);
    bit dig;
    dig = (k <= 4'd9);
    if (!r) begin
      m_entry = 0; m_shift = 0; m_wait_rel = 0; m_load_c = 0; m_load_a = 0;
      m_alarm = 0; m_digits = 0; m_secs = 0;
    end else if (m_load_c || m_load_a) begin
      m_load_c = 0; m_load_a = 0; m_digits = 0; m_secs = 0;
    end else if (m_shift) begin
      m_shift = 0; m_wait_rel = 1; m_secs = 0;
      if (m_digits < 4) m_digits++;
    end else if (m_entry) begin
      if (os && m_secs == TIMEOUT - 1) begin
        m_entry = 0; m_wait_rel = 0; m_digits = 0; m_secs = 0;
      end else if (m_wait_rel) begin
        if (!dig) m_wait_rel = 0;
        if (os) m_secs++;
      end else if (tb) begin
        if (m_digits == 4) begin m_load_c = 1; m_entry = 0; m_secs = 0; end
        else if (os) m_secs++;
      end else if (ab) begin
        if (m_digits == 4) begin m_load_a = 1; m_entry = 0; m_secs = 0; end
        else if (os) m_secs++;
      end else if (dig) begin
        m_shift = 1; m_secs = 0;
      end else if (os) begin
        m_secs++;
      end
    end else if (m_alarm) begin
      if (!ab) m_alarm = 0;
    end else if (dig) begin
      m_shift = 1; m_entry = 1; m_digits = 0; m_secs = 0;
    end else if (ab) begin
      m_alarm = 1;
    end
  endtask

  task automatic cycle(input logic r, input logic [3:0] k,
                       input logic tb, input logic ab, input logic os);
    reset = r; key = k; time_button = tb; alarm_button = ab; one_second = os;
    @(posedge clock);
    model_step(r, k, tb, ab, os);
    #1;
    check("shift",         8'(shift),         8'(m_shift));
    check("load_new_c",    8'(load_new_c),    8'(m_load_c));
    check("load_new_a",    8'(load_new_a),    8'(m_load_a));
    check("show_new_time", 8'(show_new_time), 8'(m_entry));
    check("show_a",        8'(show_a),        8'(m_alarm));
    check("digit_count",   8'(digit_count),   8'(m_digits));
    shift_cnt  += int'(shift);
    lc_cnt     += int'(load_new_c);
    la_cnt     += int'(load_new_a);
    show_a_cnt += int'(show_a);
  endtask

  task automatic clear_counts();
    shift_cnt = 0; lc_cnt = 0; la_cnt = 0; show_a_cnt = 0;
  endtask

  task automatic do_reset();
    cycle(0, 4'd10, 0, 0, 0);
    cycle(0, 4'd10, 0, 0, 0);
    cycle(1, 4'd10, 0, 0, 0);
    clear_counts();
  endtask

  // Key held for 3 cycles then released for 1.
  task automatic enter_digit(input logic [3:0] d, input int exp_count);
    cycle(1, d, 0, 0, 0);
    cycle(1, d, 0, 0, 0);
    check("digit_count_step", 8'(digit_count), 8'(exp_count));
    cycle(1, d, 0, 0, 0);
    cycle(1, 4'd10, 0, 0, 0);
  endtask

  initial begin
    logic [3:0] rk;
    clear_counts();

    // Reset held with a digit present: nothing moves.
    for (int i = 0; i < 3; i++) cycle(0, 4'd5, 0, 0, 0);
    check("reset_no_shift", 8'(shift_cnt), 8'd0);
    check("reset_digit_count", 8'(digit_count), 8'd0);
    cycle(1, 4'd5, 0, 0, 0);
    check("first_shift_after_reset", 8'(shift), 8'd1);

    // Set time 11:23.
    do_reset();
    enter_digit(4'd1, 1); enter_digit(4'd1, 2); enter_digit(4'd2, 3); enter_digit(4'd3, 4);
    cycle(1, 4'd10, 1, 0, 0);
    check("set_time_load_c_now", 8'(load_new_c), 8'd1);
    check("set_time_show_new_off", 8'(show_new_time), 8'd0);
    cycle(1, 4'd10, 0, 0, 0);
    cycle(1, 4'd10, 0, 0, 0);
    check("set_time_shifts", 8'(shift_cnt), 8'd4);
    check("set_time_load_c", 8'(lc_cnt), 8'd1);
    check("set_time_load_a", 8'(la_cnt), 8'd0);

    // Set alarm 11:30.
    clear_counts();
    enter_digit(4'd1, 1); enter_digit(4'd1, 2); enter_digit(4'd3, 3); enter_digit(4'd0, 4);
    cycle(1, 4'd10, 0, 1, 0);
    cycle(1, 4'd10, 0, 0, 0);
    cycle(1, 4'd10, 0, 0, 0);
    check("set_alarm_load_a", 8'(la_cnt), 8'd1);
    check("set_alarm_load_c", 8'(lc_cnt), 8'd0);
    check("set_alarm_show_a", 8'(show_a_cnt), 8'd0);

    // Partial entry, ignored button, then timeout.
    clear_counts();
    enter_digit(4'd7, 1); enter_digit(4'd8, 2);
    cycle(1, 4'd10, 1, 0, 0);
    check("partial_show_new", 8'(show_new_time), 8'd1);
    cycle(1, 4'd10, 0, 0, 0);
    for (int i = 1; i <= TIMEOUT; i++) begin
      cycle(1, 4'd10, 0, 0, 1);
      if (i == TIMEOUT - 1) check("timeout_not_yet", 8'(show_new_time), 8'd1);
      cycle(1, 4'd10, 0, 0, 0);
    end
    check("timeout_show_new", 8'(show_new_time), 8'd0);
    check("timeout_digit_count", 8'(digit_count), 8'd0);
    check("timeout_no_load", 8'(lc_cnt + la_cnt), 8'd0);

    // Alarm view: 20 cycles held, key 5 pressed meanwhile.
    clear_counts();
    for (int i = 0; i < 20; i++) cycle(1, (i >= 5 && i < 9) ? 4'd5 : 4'd10, 0, 1, 0);
    cycle(1, 4'd10, 0, 0, 0);
    cycle(1, 4'd10, 0, 0, 0);
    check("alarm_view_show_a_cycles", 8'(show_a_cnt), 8'd20);
    check("alarm_view_no_shift", 8'(shift_cnt), 8'd0);

    // Both buttons together: current time wins.
    clear_counts();
    enter_digit(4'd0, 1); enter_digit(4'd9, 2); enter_digit(4'd4, 3); enter_digit(4'd5, 4);
    cycle(1, 4'd10, 1, 1, 0);
    cycle(1, 4'd10, 0, 0, 0);
    check("both_load_c", 8'(lc_cnt), 8'd1);
    check("both_load_a", 8'(la_cnt), 8'd0);

    // Five digits: oldest drops out, count saturates, load still happens.
    clear_counts();
    enter_digit(4'd1, 1); enter_digit(4'd2, 2); enter_digit(4'd3, 3);
    enter_digit(4'd4, 4); enter_digit(4'd5, 4);
    check("five_digit_count", 8'(digit_count), 8'd4);
    cycle(1, 4'd10, 1, 0, 0);
    cycle(1, 4'd10, 0, 0, 0);
    check("five_digit_shifts", 8'(shift_cnt), 8'd5);
    check("five_digit_load_c", 8'(lc_cnt), 8'd1);

    // Random traffic against the model.
    rk = 4'd10;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0)
        rk = ($urandom_range(1) == 0) ? 4'($urandom_range(9)) : 4'($urandom_range(15, 10));
      cycle(($urandom_range(299) != 0), rk,
            ($urandom_range(15) == 0), ($urandom_range(15) == 0),
            ($urandom_range(5) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
